// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts a length-prefixed, XOR-checksummed byte stream and
// writes the payload sequentially into the instruction RAM starting at BASE_ADDR.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  PC,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Space left in the RAM above BASE_ADDR; 17 bits so a full 16-bit length compares safely.
  localparam logic [16:0]           SPACE  = 17'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  state_t                  state_r, next_state_s;
  logic                    xfer_s;
  logic [16:0]             len_full_s;
  logic                    last_byte_s;
  logic                    active_next_s;
  logic [15:0]             len_r;
  logic [15:0]             count_r;
  logic [7:0]              csum_r;
  logic                    in_ready_r;
  logic                    wr_en_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [DATA_WIDTH-1:0]   wr_data_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    err_r;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign xfer_s        = in_valid && in_ready_r;
  assign len_full_s    = {1'b0, in_data, len_r[7:0]};
  assign last_byte_s   = ({1'b0, count_r} + 17'd1) == {1'b0, len_r};
  assign active_next_s = (next_state_s == LEN_LO) || (next_state_s == LEN_HI) ||
                         (next_state_s == DATA)   || (next_state_s == CSUM);

  // FSM state register
  always_ff @(posedge PC or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = LEN_LO;
        else       next_state_s = IDLE;
      end
      LEN_LO: begin
        if (xfer_s) next_state_s = LEN_HI;
        else        next_state_s = LEN_LO;
      end
      LEN_HI: begin
        if (!xfer_s)                  next_state_s = LEN_HI;
        else if (len_full_s > SPACE)  next_state_s = ERR;
        else if (len_full_s == 17'd0) next_state_s = CSUM;
        else                          next_state_s = DATA;
      end
      DATA: begin
        if (xfer_s && last_byte_s) next_state_s = CSUM;
        else                       next_state_s = DATA;
      end
      CSUM: begin
        if (!xfer_s)                 next_state_s = CSUM;
        else if (in_data == csum_r)  next_state_s = DONE;
        else                         next_state_s = ERR;
      end
      DONE:    next_state_s = IDLE;
      ERR:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Frame datapath, write port and status flags
  always_ff @(posedge PC or posedge rst) begin
    if (rst) begin
      len_r      <= 16'd0;
      count_r    <= 16'd0;
      csum_r     <= 8'h00;
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= BASE_A;
      wr_data_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      in_ready_r <= active_next_s;
      busy_r     <= active_next_s;
      wr_en_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            csum_r  <= 8'h00;
            count_r <= 16'd0;
            len_r   <= 16'd0;
          end
        end
        LEN_LO: begin
          if (xfer_s) len_r[7:0] <= in_data;
        end
        LEN_HI: begin
          if (xfer_s) begin
            len_r[15:8] <= in_data;
            if (len_full_s > SPACE) err_r <= 1'b1;
          end
        end
        DATA: begin
          if (xfer_s) begin
            wr_en_r   <= 1'b1;
            wr_data_r <= DATA_WIDTH'(in_data);
            wr_addr_r <= BASE_A + count_r[ADDR_WIDTH-1:0];
            csum_r    <= csum_update(csum_r, in_data);
            count_r   <= count_r + 16'd1;
          end
        end
        CSUM: begin
          if (xfer_s) begin
            done_r <= (in_data == csum_r);
            err_r  <= (in_data != csum_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready = in_ready_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: one instance at BASE_ADDR=0 and one at BASE_ADDR=8
// share the same stream; writes are logged per instance and compared with hand-computed lists.
module tb_instr_mem_loader;
  logic       PC = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy0, wen0, busy0, done0, err0;
  logic [7:0] wa0, wd0;
  logic       rdy8, wen8, busy8, done8, err8;
  logic [7:0] wa8, wd8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wa0_q[$], wd0_q[$], wc0_q[$];
  int wa8_q[$], wd8_q[$], wc8_q[$];
  int exp_a[$], exp_d[$];

  always #5 PC = ~PC;

  instr_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(0)) u0 (
    .PC(PC), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .wr_en(wen0), .wr_addr(wa0), .wr_data(wd0),
    .busy(busy0), .done(done0), .err(err0));

  instr_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(8)) u8 (
    .PC(PC), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy8), .wr_en(wen8), .wr_addr(wa8), .wr_data(wd8),
    .busy(busy8), .done(done8), .err(err8));

  // Write logger, sampled mid-cycle
  always @(negedge PC) begin
    cyc <= cyc + 1;
    if (wen0 === 1'b1) begin
      wa0_q.push_back(int'(wa0)); wd0_q.push_back(int'(wd0)); wc0_q.push_back(cyc);
    end
    if (wen8 === 1'b1) begin
      wa8_q.push_back(int'(wa8)); wd8_q.push_back(int'(wd8)); wc8_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa0_q.delete(); wd0_q.delete(); wc0_q.delete();
    wa8_q.delete(); wd8_q.delete(); wc8_q.delete();
    exp_a.delete(); exp_d.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge PC);
  endtask

  task automatic pulse_start();
    @(negedge PC); start = 1'b1;
    @(negedge PC); start = 1'b0;
  endtask

  // Presents one byte and returns on the edge where it transfers into u0.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge PC);
    in_valid = 1'b1;
    in_data  = b;
    while (rdy0 !== 1'b1 && t < 20) begin
      @(negedge PC);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'(t), 32'd0);
    @(posedge PC);
  endtask

  task automatic idle_valid();
    @(negedge PC); in_valid = 1'b0;
  endtask

  // stride > 0: consecutive writes must be exactly that many cycles apart
  task automatic cmp_log(input string tag, input bit sel, input int stride);
    int n;
    n = sel ? wa8_q.size() : wa0_q.size();
    chk({tag, "_wcount"}, 32'(n), 32'(exp_a.size()));
    if (n == exp_a.size()) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(sel ? wa8_q[i] : wa0_q[i]), 32'(exp_a[i]));
        chk($sformatf("%s_data%0d", tag, i), 32'(sel ? wd8_q[i] : wd0_q[i]), 32'(exp_d[i]));
        if (stride > 0 && i > 0)
          chk($sformatf("%s_gap%0d", tag, i),
              32'(sel ? (wc8_q[i] - wc8_q[i-1]) : (wc0_q[i] - wc0_q[i-1])), 32'(stride));
      end
    end
  endtask

  initial begin
    // Reset state
    wait_cycles(3);
    chk("rst_in_ready", 32'(rdy0), 32'd0);
    chk("rst_wr_en", 32'(wen0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_wr_addr0", 32'(wa0), 32'h00);
    chk("rst_wr_addr8", 32'(wa8), 32'h08);
    chk("rst_wr_data", 32'(wd0), 32'h00);
    rst = 1'b0;
    wait_cycles(2);

    // 1: good 3-byte frame, back-to-back writes
    clear_logs();
    pulse_start();
    chk("t1_busy", 32'(busy0), 32'd1);
    chk("t1_ready", 32'(rdy0), 32'd1);
    send(8'h03); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    idle_valid();
    wait_cycles(2);
    exp_a = '{0, 1, 2}; exp_d = '{8'h11, 8'h22, 8'h33};
    cmp_log("t1", 1'b0, 1);
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_err", 32'(err0), 32'd0);
    chk("t1_busy_end", 32'(busy0), 32'd0);
    chk("t1_ready_end", 32'(rdy0), 32'd0);

    // 2: bad checksum, with a start pulse mid-frame that must be ignored
    clear_logs();
    pulse_start();
    chk("t2_done_cleared", 32'(done0), 32'd0);
    send(8'h03); send(8'h00); send(8'h11);
    @(negedge PC); in_valid = 1'b0; start = 1'b1;
    @(negedge PC); start = 1'b0;
    chk("t2_busy_mid", 32'(busy0), 32'd1);
    send(8'h22); send(8'h33); send(8'h01);
    idle_valid();
    wait_cycles(2);
    exp_a = '{0, 1, 2}; exp_d = '{8'h11, 8'h22, 8'h33};
    cmp_log("t2", 1'b0, 0);
    chk("t2_err", 32'(err0), 32'd1);
    chk("t2_done", 32'(done0), 32'd0);
    chk("t2_busy", 32'(busy0), 32'd0);

    // 3: length 257 exceeds a 256-byte RAM
    clear_logs();
    pulse_start();
    chk("t3_err_cleared", 32'(err0), 32'd0);
    send(8'h01); send(8'h01);
    idle_valid();
    wait_cycles(3);
    cmp_log("t3", 1'b0, 0);
    chk("t3_err", 32'(err0), 32'd1);
    chk("t3_done", 32'(done0), 32'd0);
    chk("t3_busy", 32'(busy0), 32'd0);
    chk("t3_ready", 32'(rdy0), 32'd0);

    // 4a: empty frame, checksum 00
    clear_logs();
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    idle_valid();
    wait_cycles(2);
    cmp_log("t4a", 1'b0, 0);
    chk("t4a_done", 32'(done0), 32'd1);
    chk("t4a_err", 32'(err0), 32'd0);

    // 4b: empty frame, checksum 05
    pulse_start();
    send(8'h00); send(8'h00); send(8'h05);
    idle_valid();
    wait_cycles(2);
    chk("t4b_err", 32'(err0), 32'd1);
    chk("t4b_done", 32'(done0), 32'd0);

    // Boundary: 256 bytes fills u0 exactly; u8 (248 bytes free) rejects it
    clear_logs();
    pulse_start();
    send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) send(8'(i));
    send(8'h00);
    idle_valid();
    wait_cycles(2);
    chk("full_wcount", 32'(wa0_q.size()), 32'd256);
    if (wa0_q.size() == 256) begin
      chk("full_first_addr", 32'(wa0_q[0]), 32'h00);
      chk("full_last_addr", 32'(wa0_q[255]), 32'hFF);
      chk("full_last_data", 32'(wd0_q[255]), 32'hFF);
    end
    chk("full_done0", 32'(done0), 32'd1);
    chk("full_err8", 32'(err8), 32'd1);
    chk("full_wcount8", 32'(wa8_q.size()), 32'd0);

    // 5: in_valid toggling, BASE_ADDR=8
    clear_logs();
    pulse_start();
    send(8'h04); idle_valid();
    send(8'h00); idle_valid();
    send(8'hAA); idle_valid();
    send(8'hBB); idle_valid();
    send(8'hCC); idle_valid();
    send(8'hDD); idle_valid();
    send(8'h00); idle_valid();
    wait_cycles(2);
    exp_a = '{8, 9, 10, 11}; exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cmp_log("t5", 1'b1, 2);
    chk("t5_done8", 32'(done8), 32'd1);
    chk("t5_err8", 32'(err8), 32'd0);

    // 6: reset after 2nd payload byte, then a clean frame
    pulse_start();
    send(8'h03); send(8'h00); send(8'h11); send(8'h22);
    #1;
    chk("t6_wr_en_before", 32'(wen0), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_wr_en_rst", 32'(wen0), 32'd0);
    chk("t6_busy_rst", 32'(busy0), 32'd0);
    chk("t6_ready_rst", 32'(rdy0), 32'd0);
    chk("t6_addr_rst", 32'(wa0), 32'h00);
    @(negedge PC); rst = 1'b0; in_valid = 1'b0;
    wait_cycles(1);
    clear_logs();
    pulse_start();
    send(8'h02); send(8'h00); send(8'h5A); send(8'hA5); send(8'hFF);
    idle_valid();
    wait_cycles(2);
    exp_a = '{0, 1}; exp_d = '{8'h5A, 8'hA5};
    cmp_log("t6", 1'b0, 1);
    chk("t6_done", 32'(done0), 32'd1);
    chk("t6_err", 32'(err0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
